// File: rtl/can_rx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : can_rx_frame_ctrl
// Brief    : CAN receive frame sequencer: field tracking, ID acceptance,
//            CRC comparator window, ACK drive and register-request decode.
//            Optional receive error counter enabled by CAN_RX_ERR_CNT_EN.
// Revision : 1.0  initial release
// ============================================================================
module can_rx_frame_ctrl #(
  parameter logic [10:0] ACCEPT_ID   = 11'b10101010000,
  parameter logic [10:0] ACCEPT_MASK = 11'h7FF,
  parameter int          DATA_BITS   = 46
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        rxd,
  input  logic        bit_strobe,
  input  logic        crc_correct,
  output logic        crc_en,
  output logic        ack_tx,
  output logic        frame_valid,
  output logic        frame_error,
  output logic        rw,
  output logic [14:0] addr,
  output logic [15:0] wdata,
  output logic [7:0]  rx_err_cnt
);

  localparam logic [6:0] c_ARB_LAST  = 7'd10;
  localparam logic [6:0] c_CTRL_LAST = 7'd6;
  localparam logic [6:0] c_DATA_LAST = 7'(DATA_BITS - 1);
  localparam logic [6:0] c_CRC_LAST  = 7'd14;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARB  = 3'd1,
    S_CTRL = 3'd2,
    S_DATA = 3'd3,
    S_CRC  = 3'd4,
    S_ACK  = 3'd5,
    S_EOF  = 3'd6
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [6:0]             r_cnt;
  logic [9:0]             r_id;
  logic                   r_id_ok;
  logic                   r_crc_ok;
  logic                   r_ack_first;
  logic [DATA_BITS-1:0]   r_payload;
  logic                   r_frame_valid;
  logic                   r_frame_error;
  logic                   r_rw;
  logic [14:0]            r_addr;
  logic [15:0]            r_wdata;

  logic [10:0]            w_id;
  logic                   w_crc_ok;
  logic                   w_eof_strobe;
  logic                   w_good;
  logic                   w_bad;

  assign w_id         = {r_id, rxd};
  // crc_correct arrives on the first ACK clock; bypass it so ack_tx covers the whole slot
  assign w_crc_ok     = r_ack_first ? crc_correct : r_crc_ok;
  assign w_eof_strobe = (r_state == S_EOF) && bit_strobe;
  assign w_good       = w_eof_strobe && r_id_ok && r_crc_ok && rxd;
  assign w_bad        = w_eof_strobe && r_id_ok && !(r_crc_ok && rxd);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 7'd0;
    end else if (bit_strobe) begin
      r_state <= w_state_nxt;
      if ((w_state_nxt != r_state) || (r_state == S_IDLE))
        r_cnt <= 7'd0;
      else
        r_cnt <= r_cnt + 7'd1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    crc_en      = 1'b0;
    ack_tx      = 1'b0;
    case (r_state)
      S_IDLE: if (bit_strobe && !rxd)                  w_state_nxt = S_ARB;
      S_ARB:  if (bit_strobe && r_cnt == c_ARB_LAST)   w_state_nxt = S_CTRL;
      S_CTRL: if (bit_strobe && r_cnt == c_CTRL_LAST)  w_state_nxt = S_DATA;
      S_DATA: if (bit_strobe && r_cnt == c_DATA_LAST)  w_state_nxt = S_CRC;
      S_CRC: begin
        crc_en = 1'b1;
        if (bit_strobe && r_cnt == c_CRC_LAST) w_state_nxt = S_ACK;
      end
      S_ACK: begin
        ack_tx = r_id_ok && w_crc_ok;
        if (bit_strobe) w_state_nxt = S_EOF;
      end
      S_EOF:  if (bit_strobe) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_id          <= 10'd0;
      r_id_ok       <= 1'b0;
      r_crc_ok      <= 1'b0;
      r_ack_first   <= 1'b0;
      r_payload     <= '0;
      r_frame_valid <= 1'b0;
      r_frame_error <= 1'b0;
      r_rw          <= 1'b0;
      r_addr        <= 15'd0;
      r_wdata       <= 16'd0;
    end else begin
      r_ack_first   <= (w_state_nxt == S_ACK) && (r_state != S_ACK);
      r_frame_valid <= w_good;
      r_frame_error <= w_bad;
      if (r_ack_first)
        r_crc_ok <= crc_correct;
      if (bit_strobe && r_state == S_ARB) begin
        r_id <= w_id[9:0];
        if (r_cnt == c_ARB_LAST)
          r_id_ok <= (((w_id ^ ACCEPT_ID) & ACCEPT_MASK) == 11'd0);
      end
      if (bit_strobe && r_state == S_DATA)
        r_payload <= {r_payload[DATA_BITS-2:0], rxd};
      if (w_good) begin
        r_rw    <= r_payload[DATA_BITS-1];
        r_addr  <= r_payload[DATA_BITS-2 -: 15];
        r_wdata <= r_payload[DATA_BITS-17 -: 16];
      end
    end
  end

  assign frame_valid = r_frame_valid;
  assign frame_error = r_frame_error;
  assign rw          = r_rw;
  assign addr        = r_addr;
  assign wdata       = r_wdata;

`ifdef CAN_RX_ERR_CNT_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)
      r_err_cnt <= 8'h00;
    else if (w_bad && r_err_cnt != 8'hFF)
      r_err_cnt <= r_err_cnt + 8'd1;
    else if (w_good && r_err_cnt != 8'h00)
      r_err_cnt <= r_err_cnt - 8'd1;
  end

  assign rx_err_cnt = r_err_cnt;
`else
  assign rx_err_cnt = 8'h00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_can_rx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_can_rx_frame_ctrl
// Brief    : Table-driven self-checking bench for can_rx_frame_ctrl.
// Revision : 1.0  initial release
// ============================================================================
module tb_can_rx_frame_ctrl;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        rxd;
  logic        bit_strobe;
  logic        crc_correct;
  logic        crc_en;
  logic        ack_tx;
  logic        frame_valid;
  logic        frame_error;
  logic        rw;
  logic [14:0] addr;
  logic [15:0] wdata;
  logic [7:0]  rx_err_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int n_valid = 0;
  int n_err = 0;
  int n_ack = 0;
  int n_crc = 0;

  localparam logic [10:0] c_ID_OK  = 11'b10101010000;
  localparam logic [10:0] c_ID_BAD = 11'b10101010001;

  can_rx_frame_ctrl dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .rxd         (rxd),
    .bit_strobe  (bit_strobe),
    .crc_correct (crc_correct),
    .crc_en      (crc_en),
    .ack_tx      (ack_tx),
    .frame_valid (frame_valid),
    .frame_error (frame_error),
    .rw          (rw),
    .addr        (addr),
    .wdata       (wdata),
    .rx_err_cnt  (rx_err_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_valid)           n_valid += 1;
    if (frame_error)           n_err   += 1;
    if (ack_tx)                n_ack   += 1;
    if (crc_en && bit_strobe)  n_crc   += 1;
  end

  typedef struct {
    logic [10:0] id;
    logic        rw;
    logic [14:0] addr;
    logic [15:0] wdata;
    logic        crc;
    logic        eof;
    int          gap;
    int          exp_valid;
    int          exp_err;
    logic        exp_ack;
    logic        exp_rw;
    logic [14:0] exp_addr;
    logic [15:0] exp_wdata;
    logic [7:0]  exp_cnt;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp += 1;
    if (act !== exp) begin
      n_bad += 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b, input int gap);
    rxd        = b;
    bit_strobe = 1'b1;
    tick();
    bit_strobe = 1'b0;
    repeat (gap) tick();
  endtask

  // SOF, ID, CTRL, payload (rw/addr/wdata/padding), CRC, ACK slot, EOF
  task automatic send_frame(input logic [10:0] id, input logic r, input logic [14:0] a,
                            input logic [15:0] d, input logic e, input int gap, input int nbits);
    logic [81:0] f;
    f = {1'b0, id, 7'b0000000, r, a, d, 14'h2AAA, 15'h7FFF, 1'b1, e};
    for (int i = 0; i < nbits; i++) send_bit(f[81-i], gap);
  endtask

  function automatic logic [7:0] exp_cnt_of(input logic [7:0] c);
`ifdef CAN_RX_ERR_CNT_EN
    return c;
`else
    return (c & 8'h00);
`endif
  endfunction

  initial begin
    int s_valid, s_err, s_ack, s_crc;

    vecs[0] = '{c_ID_OK,  1'b1, 15'h1234, 16'hBEEF, 1'b1, 1'b1, 1, 1, 0, 1'b1, 1'b1, 15'h1234, 16'hBEEF, 8'd0};
    vecs[1] = '{c_ID_OK,  1'b0, 15'h0555, 16'h1111, 1'b0, 1'b1, 1, 0, 1, 1'b0, 1'b1, 15'h1234, 16'hBEEF, 8'd1};
    vecs[2] = '{c_ID_BAD, 1'b0, 15'h0555, 16'h1111, 1'b1, 1'b1, 1, 0, 0, 1'b0, 1'b1, 15'h1234, 16'hBEEF, 8'd1};
    vecs[3] = '{c_ID_OK,  1'b0, 15'h0555, 16'h1111, 1'b1, 1'b0, 2, 0, 1, 1'b1, 1'b1, 15'h1234, 16'hBEEF, 8'd2};
    vecs[4] = '{c_ID_OK,  1'b0, 15'h7ABC, 16'h0F0F, 1'b1, 1'b1, 0, 1, 0, 1'b1, 1'b0, 15'h7ABC, 16'h0F0F, 8'd1};
    vecs[5] = '{c_ID_OK,  1'b1, 15'h1234, 16'hBEEF, 1'b1, 1'b1, 3, 1, 0, 1'b1, 1'b1, 15'h1234, 16'hBEEF, 8'd0};

    n_rst       = 1'b0;
    rxd         = 1'b1;
    bit_strobe  = 1'b0;
    crc_correct = 1'b0;
    repeat (3) tick();
    chk("reset_outputs", 64'({crc_en, ack_tx, frame_valid, frame_error, rw, addr, wdata, rx_err_cnt}), 64'd0);
    n_rst = 1'b1;
    tick();
    send_bit(1'b1, 1);
    send_bit(1'b1, 1);

    for (int v = 0; v < 6; v++) begin
      s_valid = n_valid; s_err = n_err; s_ack = n_ack; s_crc = n_crc;
      crc_correct = vecs[v].crc;
      send_frame(vecs[v].id, vecs[v].rw, vecs[v].addr, vecs[v].wdata, vecs[v].eof, vecs[v].gap, 82);
      repeat (3) tick();
      chk($sformatf("v%0d_valid_pulses", v), 64'(n_valid - s_valid), 64'(vecs[v].exp_valid));
      chk($sformatf("v%0d_error_pulses", v), 64'(n_err - s_err), 64'(vecs[v].exp_err));
      chk($sformatf("v%0d_ack_clocks", v), 64'(n_ack - s_ack),
          vecs[v].exp_ack ? 64'(vecs[v].gap + 1) : 64'd0);
      chk($sformatf("v%0d_crc_en_strobes", v), 64'(n_crc - s_crc), 64'd15);
      chk($sformatf("v%0d_rw", v), 64'(rw), 64'(vecs[v].exp_rw));
      chk($sformatf("v%0d_addr", v), 64'(addr), 64'(vecs[v].exp_addr));
      chk($sformatf("v%0d_wdata", v), 64'(wdata), 64'(vecs[v].exp_wdata));
      chk($sformatf("v%0d_rx_err_cnt", v), 64'(rx_err_cnt), 64'(exp_cnt_of(vecs[v].exp_cnt)));
    end

    // Reset asserted while the 21st DATA bit is on the bus
    s_valid = n_valid; s_err = n_err;
    crc_correct = 1'b1;
    send_frame(c_ID_OK, 1'b0, 15'h0555, 16'h1111, 1'b1, 1, 39);
    rxd        = 1'b1;
    bit_strobe = 1'b1;
    #2 n_rst = 1'b0;
    #1;
    chk("midreset_outputs", 64'({crc_en, ack_tx, frame_valid, frame_error, rw, addr, wdata, rx_err_cnt}), 64'd0);
    bit_strobe = 1'b0;
    repeat (3) tick();
    n_rst = 1'b1;
    repeat (2) tick();
    chk("midreset_no_pulse", 64'((n_valid - s_valid) + (n_err - s_err)), 64'd0);

    s_valid = n_valid; s_err = n_err;
    send_frame(c_ID_OK, 1'b1, 15'h0ACE, 16'hCAFE, 1'b1, 1, 82);
    repeat (3) tick();
    chk("after_reset_valid", 64'(n_valid - s_valid), 64'd1);
    chk("after_reset_error", 64'(n_err - s_err), 64'd0);
    chk("after_reset_rw", 64'(rw), 64'd1);
    chk("after_reset_addr", 64'(addr), 64'h0ACE);
    chk("after_reset_wdata", 64'(wdata), 64'hCAFE);
    chk("after_reset_cnt_floor", 64'(rx_err_cnt), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
